// File: rtl/cnt_sched_pkg.sv
// Shared types and default sizing for the counter load/clear scheduler.
package cnt_sched_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CLEAR   = 2'd1,
    LOAD    = 2'd2,
    RELEASE = 2'd3
  } state_t;

  localparam int DEF_NREQ     = 4;
  localparam int DEF_WIDTH    = 8;
  localparam int DEF_HOLD_CYC = 2;

endpackage

// File: rtl/rr_pick.sv
// Rotate-priority picker: first set request after 'last', wrapping modulo NREQ.
module rr_pick #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] last,
  output logic [NREQ-1:0]         win_onehot,
  output logic [$clog2(NREQ)-1:0] win_idx
);

  localparam int IW = $clog2(NREQ);

  logic [NREQ-1:0] rot;
  logic            found;

  // rot[0] is the requester just after the previous winner
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_rot
    assign rot[gi] = req[IW'((int'(last) + 1 + gi) % NREQ)];
  end

  always_comb begin
    win_idx = '0;
    found   = 1'b0;
    for (int j = 0; j < NREQ; j++) begin
      if (!found && rot[j]) begin
        found   = 1'b1;
        win_idx = IW'((int'(last) + 1 + j) % NREQ);
      end
    end
    win_onehot = found ? (NREQ'(1) << win_idx) : '0;
  end

endmodule

// File: rtl/cnt_load_sched.sv
// Arbitrates preset/clear requests onto a shared counter's clr/pr/n inputs.
// Optional readback check of the counter output: define CNT_LOAD_SCHED_CHECK_EN.
module cnt_load_sched
  import cnt_sched_pkg::*;
#(
  parameter int NREQ     = DEF_NREQ,
  parameter int WIDTH    = DEF_WIDTH,
  parameter int HOLD_CYC = DEF_HOLD_CYC
) (
  input  logic                    clk,
  input  logic                    clr_n,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*WIDTH-1:0]   req_val,
  input  logic                    clr_req,
`ifdef CNT_LOAD_SCHED_CHECK_EN
  input  logic [WIDTH-1:0]        cnt_q,
  output logic                    err,
`endif
  output logic [NREQ-1:0]         gnt,
  output logic [NREQ-1:0]         done,
  output logic                    cnt_clr,
  output logic                    cnt_pr,
  output logic [WIDTH-1:0]        cnt_n,
  output logic                    busy
);

  localparam int IW = $clog2(NREQ);
  localparam int HW = $clog2(HOLD_CYC + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYC - 1);

  state_t          state_reg;
  logic [HW-1:0]   hold_reg;
  logic [IW-1:0]   last_reg;
  logic            pend_reg;
  logic [NREQ-1:0] win_onehot;
  logic [IW-1:0]   win_idx;
  logic [WIDTH-1:0] vals [NREQ];
  logic            hold_end;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_vals
    assign vals[gi] = req_val[gi*WIDTH +: WIDTH];
  end

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req        (req),
    .last       (last_reg),
    .win_onehot (win_onehot),
    .win_idx    (win_idx)
  );

  assign hold_end = (hold_reg == HOLD_LAST);
  assign busy     = (state_reg != IDLE);

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_reg <= IDLE;
      hold_reg  <= '0;
      last_reg  <= IW'(NREQ - 1);
      pend_reg  <= 1'b0;
      gnt       <= '0;
      done      <= '0;
      cnt_clr   <= 1'b0;
      cnt_pr    <= 1'b0;
      cnt_n     <= '0;
    end else begin
      done <= '0;
      case (state_reg)
        IDLE: begin
          hold_reg <= '0;
          // A pending or same-cycle clear always wins over presets
          if (pend_reg || clr_req) begin
            pend_reg  <= 1'b0;
            cnt_clr   <= 1'b1;
            state_reg <= CLEAR;
          end else if (|req) begin
            gnt       <= win_onehot;
            last_reg  <= win_idx;
            cnt_n     <= vals[win_idx];
            cnt_pr    <= 1'b1;
            state_reg <= LOAD;
          end
        end
        CLEAR, LOAD: begin
          pend_reg <= pend_reg | clr_req;
          if (hold_end) begin
            cnt_clr   <= 1'b0;
            cnt_pr    <= 1'b0;
            gnt       <= '0;
            done      <= gnt;   // zero after a CLEAR, so no completion pulse
            hold_reg  <= '0;
            state_reg <= RELEASE;
          end else begin
            hold_reg <= hold_reg + 1'b1;
          end
        end
        RELEASE: begin
          pend_reg  <= pend_reg | clr_req;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

`ifdef CNT_LOAD_SCHED_CHECK_EN
  // Counter must reflect the forced value by the final hold cycle
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      err <= 1'b0;
    end else if (hold_end &&
                 ((state_reg == LOAD  && cnt_q != cnt_n) ||
                  (state_reg == CLEAR && cnt_q != '0))) begin
      err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_cnt_load_sched.sv
// Self-checking bench for cnt_load_sched: directed scenarios plus random traffic vs an age-based model.
module tb_cnt_load_sched;

  localparam int NREQ = 4;
  localparam int W    = 8;
  localparam int HOLD = 2;

  logic            clk = 1'b0;
  logic            clr_n = 1'b0;
  logic [NREQ-1:0] req = '0;
  logic [NREQ*W-1:0] req_val = '0;
  logic            clr_req = 1'b0;
  logic [NREQ-1:0] gnt, done;
  logic            cnt_clr, cnt_pr, busy;
  logic [W-1:0]    cnt_n;

`ifdef CNT_LOAD_SCHED_CHECK_EN
  logic [W-1:0] cnt_q;
  logic         err;
  bit           q_bad = 1'b0;
  assign cnt_q = (q_bad || cnt_clr) ? '0 : cnt_n;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model: each operation is described by its start edge and kind
  int   ecount = 0;
  bit   m_active = 1'b0;
  bit   m_load = 1'b0;
  int   m_start = 0;
  int   m_win = 0;
  int   m_last = NREQ - 1;
  bit   m_pend = 1'b0;
  logic [W-1:0] m_n = '0;

  always #5 clk = ~clk;

  cnt_load_sched #(.NREQ(NREQ), .WIDTH(W), .HOLD_CYC(HOLD)) dut (
    .clk     (clk),
    .clr_n   (clr_n),
    .req     (req),
    .req_val (req_val),
    .clr_req (clr_req),
`ifdef CNT_LOAD_SCHED_CHECK_EN
    .cnt_q   (cnt_q),
    .err     (err),
`endif
    .gnt     (gnt),
    .done    (done),
    .cnt_clr (cnt_clr),
    .cnt_pr  (cnt_pr),
    .cnt_n   (cnt_n),
    .busy    (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_active = 1'b0;
    m_last   = NREQ - 1;
    m_pend   = 1'b0;
    m_n      = '0;
  endtask

  task automatic model_edge();
    bit idle_before;
    bit found;
    ecount++;
    idle_before = !m_active || (ecount - m_start) >= HOLD + 2;
    if (idle_before) begin
      if (m_pend || clr_req) begin
        m_pend = 1'b0; m_active = 1'b1; m_load = 1'b0; m_start = ecount;
      end else if (req != '0) begin
        found = 1'b0;
        for (int off = 1; off <= NREQ; off++) begin
          if (!found && req[(m_last + off) % NREQ]) begin
            found = 1'b1;
            m_win = (m_last + off) % NREQ;
          end
        end
        m_last = m_win;
        m_n = req_val[m_win*W +: W];
        m_active = 1'b1; m_load = 1'b1; m_start = ecount;
      end
    end else if (clr_req) begin
      m_pend = 1'b1;
    end
  endtask

  task automatic step(input string tag);
    int a;
    logic [NREQ-1:0] e_gnt, e_done;
    logic e_clr, e_pr, e_busy;
    @(posedge clk);
    model_edge();
    #1;
    a = ecount - m_start;
    e_gnt = '0; e_done = '0; e_clr = 1'b0; e_pr = 1'b0; e_busy = 1'b0;
    if (m_active && a < HOLD) begin
      e_busy = 1'b1;
      if (m_load) begin e_pr = 1'b1; e_gnt = NREQ'(1) << m_win; end
      else e_clr = 1'b1;
    end else if (m_active && a == HOLD) begin
      e_busy = 1'b1;
      if (m_load) e_done = NREQ'(1) << m_win;
    end
    chk({tag, ".gnt"},     32'(gnt),     32'(e_gnt));
    chk({tag, ".done"},    32'(done),    32'(e_done));
    chk({tag, ".cnt_clr"}, 32'(cnt_clr), 32'(e_clr));
    chk({tag, ".cnt_pr"},  32'(cnt_pr),  32'(e_pr));
    chk({tag, ".cnt_n"},   32'(cnt_n),   32'(m_n));
    chk({tag, ".busy"},    32'(busy),    32'(e_busy));
    $display("[%0t] %s req=%b clr_req=%b gnt=%b done=%b clr=%b pr=%b n=%02h busy=%b",
             $time, tag, req, clr_req, gnt, done, cnt_clr, cnt_pr, cnt_n, busy);
  endtask

  // Asynchronous reset pulse placed between clock edges; outputs checked without a clock
  task automatic do_reset(input string tag);
    clr_n = 1'b0;
    #1;
    model_reset();
    chk({tag, ".rst_gnt"},  32'(gnt),     32'(0));
    chk({tag, ".rst_done"}, 32'(done),    32'(0));
    chk({tag, ".rst_clr"},  32'(cnt_clr), 32'(0));
    chk({tag, ".rst_pr"},   32'(cnt_pr),  32'(0));
    chk({tag, ".rst_n"},    32'(cnt_n),   32'(0));
    chk({tag, ".rst_busy"}, 32'(busy),    32'(0));
    #1;
    clr_n = 1'b1;
  endtask

  initial begin
    int order[$];
    logic [NREQ-1:0] prev_g;

    #12;
    do_reset("init");

    // Single request from requester 2
    req = 4'b0100;
    req_val[2*W +: W] = 8'h5A;
    step("single0");
    chk("single.gnt_first", 32'(gnt), 32'h4);
    chk("single.n_first", 32'(cnt_n), 32'h5A);
    req = '0;
    for (int i = 1; i < 5; i++) step("single");

    // Round robin from a fresh pointer: expect 0,1,2,3,0
    do_reset("rr");
    req = 4'b1111;
    for (int i = 0; i < NREQ; i++) req_val[i*W +: W] = W'($urandom);
    prev_g = '0;
    for (int i = 0; i < 20; i++) begin
      step("rr");
      if (gnt != '0 && gnt != prev_g) order.push_back($clog2(gnt));
      prev_g = gnt;
    end
    req = '0;
    chk("rr.count", 32'(order.size()), 32'd5);
    if (order.size() == 5) begin
      chk("rr.order0", 32'(order[0]), 32'd0);
      chk("rr.order1", 32'(order[1]), 32'd1);
      chk("rr.order2", 32'(order[2]), 32'd2);
      chk("rr.order3", 32'(order[3]), 32'd3);
      chk("rr.order4", 32'(order[4]), 32'd0);
    end
    for (int i = 0; i < 4; i++) step("rr_tail");

    // Clear and request in the same cycle: clear first
    req = 4'b0001; req_val[0 +: W] = 8'hA7; clr_req = 1'b1;
    step("clrpri0");
    chk("clrpri.cnt_clr_first", 32'(cnt_clr), 32'd1);
    clr_req = 1'b0;
    for (int i = 0; i < 4; i++) step("clrpri");
    req = '0;
    for (int i = 0; i < 5; i++) step("clrpri");

    // Clear arriving during a load is serviced right after it
    req = 4'b0010; req_val[W +: W] = 8'h3C;
    step("clrload0");
    req = '0; clr_req = 1'b1;
    step("clrload1");
    clr_req = 1'b0;
    for (int i = 0; i < 9; i++) step("clrload");

    // Reset in the second hold cycle of a load
    req = 4'b0100; req_val[2*W +: W] = 8'h77;
    step("midrst0");
    req = '0;
    step("midrst1");
    req = 4'b0010; req_val[W +: W] = 8'h21;
    do_reset("midrst");
    step("midrst_after0");
    chk("midrst.gnt_after", 32'(gnt), 32'h2);
    req = '0;
    for (int i = 0; i < 4; i++) step("midrst_after");

    // Withdrawal and value change after grant
    req = 4'b1000; req_val[3*W +: W] = 8'hC3;
    step("wd0");
    req = '0; req_val[3*W +: W] = 8'h11;
    for (int i = 0; i < 4; i++) begin
      step("wd");
      chk("wd.n_stable", 32'(cnt_n), 32'hC3);
    end

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      for (int r = 0; r < NREQ; r++) begin
        if (!req[r] && $urandom_range(3) == 0) begin
          req[r] = 1'b1;
          req_val[r*W +: W] = W'($urandom);
        end else if ($urandom_range(4) == 0) begin
          req_val[r*W +: W] = W'($urandom);
        end
      end
      clr_req = ($urandom_range(9) == 0);
      step("rand");
      for (int r = 0; r < NREQ; r++)
        if ((gnt[r] && $urandom_range(1) == 0) || done[r]) req[r] = 1'b0;
    end
    req = '0; clr_req = 1'b0;
    for (int i = 0; i < 6; i++) step("rand_tail");

`ifdef CNT_LOAD_SCHED_CHECK_EN
    do_reset("chk");
    chk("chk.err_reset", 32'(err), 32'd0);
    req = 4'b0001; req_val[0 +: W] = 8'h33;
    step("chk_ok0");
    req = '0;
    for (int i = 0; i < 4; i++) step("chk_ok");
    clr_req = 1'b1;
    step("chk_clr0");
    clr_req = 1'b0;
    for (int i = 0; i < 4; i++) step("chk_clr");
    chk("chk.err_clean", 32'(err), 32'd0);
    q_bad = 1'b1;
    req = 4'b0001;
    step("chk_bad0");
    req = '0;
    step("chk_bad1");
    chk("chk.err_before", 32'(err), 32'd0);
    step("chk_bad2");
    chk("chk.err_set", 32'(err), 32'd1);
    q_bad = 1'b0;
    for (int i = 0; i < 4; i++) step("chk_bad");
    chk("chk.err_sticky", 32'(err), 32'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
